class_vote_window: RTL and testbench

CLASS_VOTE_WINDOW -- requirements
Module: class_vote_window

---
 rtl/class_vote_window.sv | 158 +++++++++++++++
 tb/tb_class_vote_window.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/class_vote_window.sv
// Windowed majority vote over winner-take-all readout samples.
// Optional CLASS_VOTE_DROP_CNT_EN adds dropped_o, a saturating count of discarded samples.
module class_vote_window #(
  parameter int                 NUM_CLASSES = 10,
  parameter int                 WIDTH_P     = 8,
  parameter int                 WINDOW      = 16,
  parameter logic [WIDTH_P-1:0] MIN_VALUE   = 8'd1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [WIDTH_P-1:0] idx_i,
  input  logic [WIDTH_P-1:0] value_i,
  input  logic               result_ready_i,
  output logic               result_valid_o,
  output logic [WIDTH_P-1:0] class_o,
  output logic [WIDTH_P-1:0] votes_o,
  output logic               busy_o
`ifdef CLASS_VOTE_DROP_CNT_EN
  ,
  output logic [7:0]         dropped_o
`endif
);

  localparam int SW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [SW-1:0]      SCAN_LAST = SW'(NUM_CLASSES - 1);
  localparam logic [7:0]         WIN_LAST  = 8'(WINDOW - 1);
  localparam logic [WIDTH_P-1:0] NO_CLASS  = '1;

  typedef enum logic [1:0] {
    COLLECT,
    DECIDE,
    HOLD
  } state_e;

  state_e                        state_q, state_d;
  logic [7:0]                    sample_q, sample_d;
  logic [NUM_CLASSES-1:0][7:0]   vote_q, vote_d;
  logic [SW-1:0]                 scan_q, scan_d;
  logic [7:0]                    best_cnt_q, best_cnt_d;
  logic [SW-1:0]                 best_idx_q, best_idx_d;
  logic                          rv_q, rv_d;
  logic [WIDTH_P-1:0]            class_q, class_d;
  logic [WIDTH_P-1:0]            votes_q, votes_d;
  logic [7:0]                    cand_cnt;
  logic [SW-1:0]                 cand_idx;

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    vote_d     = vote_q;
    scan_d     = scan_q;
    best_cnt_d = best_cnt_q;
    best_idx_d = best_idx_q;
    rv_d       = rv_q;
    class_d    = class_q;
    votes_d    = votes_q;
    cand_cnt   = best_cnt_q;
    cand_idx   = best_idx_q;
    unique case (state_q)
      COLLECT: begin
        if (valid_i) begin
          sample_d = sample_q + 8'd1;
          for (int c = 0; c < NUM_CLASSES; c++) begin
            if (idx_i == WIDTH_P'(c) && value_i >= MIN_VALUE) begin
              vote_d[c] = vote_q[c] + 8'd1;
            end
          end
          if (sample_q == WIN_LAST) begin
            state_d    = DECIDE;
            scan_d     = '0;
            best_cnt_d = '0;
            best_idx_d = '0;
          end
        end
      end
      DECIDE: begin
        // strict compare keeps the lowest index on ties
        if (vote_q[scan_q] > best_cnt_q) begin
          cand_cnt = vote_q[scan_q];
          cand_idx = scan_q;
        end
        best_cnt_d = cand_cnt;
        best_idx_d = cand_idx;
        if (scan_q == SCAN_LAST) begin
          state_d = HOLD;
          rv_d    = 1'b1;
          if (cand_cnt == 8'd0) begin
            class_d = NO_CLASS;
            votes_d = '0;
          end else begin
            class_d = WIDTH_P'(cand_idx);
            votes_d = WIDTH_P'(cand_cnt);
          end
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      HOLD: begin
        if (result_ready_i) begin
          state_d  = COLLECT;
          rv_d     = 1'b0;
          vote_d   = '0;
          sample_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= COLLECT;
      sample_q   <= '0;
      vote_q     <= '0;
      scan_q     <= '0;
      best_cnt_q <= '0;
      best_idx_q <= '0;
      rv_q       <= 1'b0;
      class_q    <= NO_CLASS;
      votes_q    <= '0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      vote_q     <= vote_d;
      scan_q     <= scan_d;
      best_cnt_q <= best_cnt_d;
      best_idx_q <= best_idx_d;
      rv_q       <= rv_d;
      class_q    <= class_d;
      votes_q    <= votes_d;
    end
  end

  assign result_valid_o = rv_q;
  assign class_o        = class_q;
  assign votes_o        = votes_q;
  assign busy_o         = (state_q != COLLECT);

`ifdef CLASS_VOTE_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (valid_i && state_q != COLLECT && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign dropped_o = drop_q;
`endif

endmodule

// File: tb/tb_class_vote_window.sv
// Randomized + directed bench for class_vote_window against a window-level vote model.
module tb_class_vote_window;

  localparam int NC  = 10;
  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] idx_i = '0;
  logic [7:0] value_i = '0;
  logic       result_ready_i = 1'b0;
  logic       result_valid_o;
  logic [7:0] class_o;
  logic [7:0] votes_o;
  logic       busy_o;
`ifdef CLASS_VOTE_DROP_CNT_EN
  logic [7:0] dropped_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  class_vote_window dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .idx_i          (idx_i),
    .value_i        (value_i),
    .result_ready_i (result_ready_i),
    .result_valid_o (result_valid_o),
    .class_o        (class_o),
    .votes_o        (votes_o),
    .busy_o         (busy_o)
`ifdef CLASS_VOTE_DROP_CNT_EN
    ,
    .dropped_o      (dropped_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-window tallies, argmax at window end,
  // result appears NC edges later and stays until accepted.
  int m_cnt [NC];
  int m_samples = 0;
  int m_mode = 0;
  int m_wait = 0;
  int m_rv = 0;
  int m_class = 255;
  int m_votes = 0;
  int m_dec_class = 255;
  int m_dec_votes = 0;
  int m_drop = 0;
  int m_decs = 0;
  int dut_decs = 0;
  bit started = 0;
  bit prev_rv = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("result_valid", int'(result_valid_o), m_rv);
      chk("class", int'(class_o), m_class);
      chk("votes", int'(votes_o), m_votes);
      chk("busy", int'(busy_o), int'(m_mode != 0));
`ifdef CLASS_VOTE_DROP_CNT_EN
      chk("dropped", int'(dropped_o), m_drop);
`endif
      if (result_valid_o && !prev_rv) dut_decs++;
      prev_rv = result_valid_o;
    end
    if (rst_i) begin
      foreach (m_cnt[c]) m_cnt[c] = 0;
      m_samples = 0; m_mode = 0; m_wait = 0; m_rv = 0;
      m_class = 255; m_votes = 0; m_drop = 0;
      started = 1;
    end else if (m_mode == 0) begin
      if (valid_i) begin
        m_samples++;
        if (idx_i < NC && value_i >= 1) m_cnt[idx_i]++;
        if (m_samples == WIN) begin
          m_dec_votes = 0;
          m_dec_class = 255;
          for (int c = 0; c < NC; c++)
            if (m_cnt[c] > m_dec_votes) begin
              m_dec_votes = m_cnt[c];
              m_dec_class = c;
            end
          m_mode = 1;
          m_wait = NC;
        end
      end
    end else begin
      if (valid_i && m_drop < 255) m_drop++;
      if (m_mode == 1) begin
        m_wait--;
        if (m_wait == 0) begin
          m_mode = 2; m_rv = 1;
          m_class = m_dec_class; m_votes = m_dec_votes;
          m_decs++;
        end
      end else if (result_ready_i) begin
        m_mode = 0; m_rv = 0; m_samples = 0;
        foreach (m_cnt[c]) m_cnt[c] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int idx, input int val);
    valid_i = 1'b1; idx_i = 8'(idx); value_i = 8'(val);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_rv(output int lat);
    lat = 0;
    while (!result_valid_o && lat < 200) begin
      tick();
      lat++;
    end
    if (!result_valid_o) chk("rv_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rv", int'(result_valid_o), 0);
    chk("rst_class", int'(class_o), 255);
    chk("rst_votes", int'(votes_o), 0);
    chk("rst_busy", int'(busy_o), 0);
  endtask

  task automatic accept();
    result_ready_i = 1'b1; tick(); result_ready_i = 1'b0;
    chk("ack_rv", int'(result_valid_o), 0);
    chk("ack_busy", int'(busy_o), 0);
  endtask

  task automatic window_expect(input int idx, input int exp_cls, input int exp_votes);
    int lat;
    for (int i = 0; i < WIN; i++) send(idx, 20);
    wait_rv(lat);
    chk("win_class", int'(class_o), exp_cls);
    chk("win_votes", int'(votes_o), exp_votes);
  endtask

  initial begin
    int lat;
`ifdef CLASS_VOTE_DROP_CNT_EN
    int d0;
`endif
    tick();
    do_reset();
    chk_reset_vals();

    for (int i = 0; i < WIN; i++) send(3, 50);
    wait_rv(lat);
    chk("lat", lat, 10);
    chk("t1_class", int'(class_o), 3);
    chk("t1_votes", int'(votes_o), 16);
    accept();
    chk("t1_keep_class", int'(class_o), 3);

    for (int i = 0; i < 8; i++) send(2, 20);
    for (int i = 0; i < 8; i++) send(5, 20);
    wait_rv(lat);
    chk("tie_class", int'(class_o), 2);
    chk("tie_votes", int'(votes_o), 8);
    accept();

    for (int i = 0; i < WIN; i++) send(4, 0);
    wait_rv(lat);
    chk("v0_class", int'(class_o), 255);
    chk("v0_votes", int'(votes_o), 0);
    accept();

    window_expect(12, 255, 0);
`ifdef CLASS_VOTE_DROP_CNT_EN
    d0 = int'(dropped_o);
`endif
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1;
      idx_i = 8'($urandom_range(0, 9));
      value_i = 8'($urandom_range(1, 255));
      tick();
    end
    valid_i = 1'b0;
    chk("hold_rv", int'(result_valid_o), 1);
    chk("hold_class", int'(class_o), 255);
`ifdef CLASS_VOTE_DROP_CNT_EN
    chk("hold_drops", int'(dropped_o) - d0, 20);
`endif
    accept();
    window_expect(4, 4, 16);
    accept();

    for (int i = 0; i < WIN; i++) send(1, 9);
    repeat (3) tick();
    do_reset();
    chk_reset_vals();
    for (int i = 0; i < 9; i++) send(1, 9);
    do_reset();
    chk_reset_vals();
    window_expect(1, 1, 16);
    do_reset();
    chk_reset_vals();
    for (int i = 0; i < WIN; i++) send(7, 9);
    wait_rv(lat);
    chk("r_lat", lat, 10);
    chk("r_class", int'(class_o), 7);
    chk("r_votes", int'(votes_o), 16);

    result_ready_i = 1'b1;
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      idx_i = 8'($urandom_range(0, 11));
      value_i = 8'($urandom_range(0, 3));
      tick();
    end
    for (int i = 0; i < 800; i++) begin
      rst_i = ($urandom_range(0, 149) == 0);
      result_ready_i = ($urandom_range(0, 3) == 0);
      valid_i = ($urandom_range(0, 2) != 0);
      idx_i = 8'($urandom_range(0, 2) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 3));
      value_i = 8'($urandom_range(0, 2));
      tick();
    end
    rst_i = 1'b0; valid_i = 1'b0; result_ready_i = 1'b0;
    tick();
    chk("decisions", dut_decs, m_decs);
    do_reset();
    chk_reset_vals();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
